// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int CLKS_PER_BIT_DEF = 868;

    // One frame (start + 8 data + stop + slack) plus a small margin.
    function automatic int timeout_clks(input int clks_per_bit);
        return 11 * clks_per_bit + 16;
    endfunction

    localparam int TIMEOUT_CLKS_DEF = timeout_clks(CLKS_PER_BIT_DEF);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle seen by the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_Req_DV;
    logic [NUM_REQ*8-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   o_Req_Ack;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 i_TX_Done;
    logic [IW-1:0]        o_Grant_Idx;
    logic                 o_Busy;
    logic                 o_Timeout;

    modport slave (
        input  i_Req_DV, i_Req_Byte, i_TX_Done,
        output o_Req_Ack, o_TX_DV, o_TX_Byte,
        output o_Grant_Idx, o_Busy, o_Timeout
    );

    modport master (
        output i_Req_DV, i_Req_Byte, i_TX_Done,
        input  o_Req_Ack, o_TX_DV, o_TX_Byte,
        input  o_Grant_Idx, o_Busy, o_Timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: nearest requester after the last winner, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);
    localparam int IW = $clog2(NUM_REQ);

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx   = last;
        valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[IW'((int'(last) + i) % NUM_REQ)]) begin
                idx   = IW'((int'(last) + i) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter.
// Optional watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_CLKS = timeout_clks(CLKS_PER_BIT)
) (
    input logic               i_Clk,
    input logic               i_Rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [NUM_REQ-1:0] ack;
    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic [IW-1:0]      grant;
    logic               busy;
    logic               tmo;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               wd_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.i_Req_DV),
        .last  (grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);

    logic [CW-1:0] wd_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (!wd_hit) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    assign wd_hit = (wd_cnt == CW'(TIMEOUT_CLKS - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            ack     <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
            grant   <= IW'(NUM_REQ - 1);
            busy    <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            ack   <= '0;
            tx_dv <= 1'b0;
            tmo   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= BUSY;
                        ack     <= NUM_REQ'(1) << pick_idx;
                        tx_dv   <= 1'b1;
                        tx_byte <= bus.i_Req_Byte[{pick_idx, 3'b000} +: 8];
                        grant   <= pick_idx;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.i_TX_Done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wd_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tmo   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Req_Ack   = ack;
    assign bus.o_TX_DV     = tx_dv;
    assign bus.o_TX_Byte   = tx_byte;
    assign bus.o_Grant_Idx = grant;
    assign bus.o_Busy      = busy;
    assign bus.o_Timeout   = tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CLKS=20).
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  bytes;
        logic         valid;
        int           idx;
        logic [7:0]   byt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;
    int   last;
    vec_t tbl[8];
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .TIMEOUT_CLKS (20)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_grant(input string nm, input int idx,
                             input logic [7:0] byt);
        chk({nm, " tx_dv"}, 32'(bus.o_TX_DV), 32'd1);
        chk({nm, " ack"}, 32'(bus.o_Req_Ack), 32'(1) << idx);
        chk({nm, " idx"}, 32'(bus.o_Grant_Idx), 32'(idx));
        chk({nm, " byte"}, 32'(bus.o_TX_Byte), 32'(byt));
        chk({nm, " busy"}, 32'(bus.o_Busy), 32'd1);
    endtask

    task automatic chk_quiet(input string nm, input logic busy);
        chk({nm, " tx_dv"}, 32'(bus.o_TX_DV), 32'd0);
        chk({nm, " ack"}, 32'(bus.o_Req_Ack), 32'd0);
        chk({nm, " busy"}, 32'(bus.o_Busy), 32'(busy));
    endtask

    task automatic finish_tx(input string nm);
        bus.i_TX_Done = 1'b1;
        tick();
        bus.i_TX_Done = 1'b0;
        chk_quiet({nm, " done"}, 1'b0);
    endtask

    // Winner = pending requester at the smallest forward distance from last.
    function automatic int model_pick(input logic [N-1:0] req, input int lst);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N + 1;
        for (int k = 0; k < N; k++) begin
            d = (k - lst - 1 + 2 * N) % N;
            if (req[k] && d < bd) begin
                bd   = d;
                best = k;
            end
        end
        return best;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        logic [31:0]  b;
        int           w;
        int           len;

        tbl[0] = '{4'b0001, 32'h0000_0041, 1'b1, 0, 8'h41};
        tbl[1] = '{4'b1111, 32'h1312_1110, 1'b1, 1, 8'h11};
        tbl[2] = '{4'b1001, 32'h4433_2211, 1'b1, 3, 8'h44};
        tbl[3] = '{4'b0110, 32'h00CC_BB00, 1'b1, 1, 8'hBB};
        tbl[4] = '{4'b0001, 32'h0000_0055, 1'b1, 0, 8'h55};
        tbl[5] = '{4'b0101, 32'h0066_0077, 1'b1, 2, 8'h66};
        tbl[6] = '{4'b1000, 32'h9900_0000, 1'b1, 3, 8'h99};
        tbl[7] = '{4'b0000, 32'hFFFF_FFFF, 1'b0, 3, 8'h00};

        rst_n = 1'b1;
        bus.i_Req_DV = '0;
        bus.i_Req_Byte = '0;
        bus.i_TX_Done = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        chk_quiet("reset", 1'b0);
        chk("reset byte", 32'(bus.o_TX_Byte), 32'h0);
        chk("reset idx", 32'(bus.o_Grant_Idx), 32'd3);
        chk("reset tmo", 32'(bus.o_Timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.i_Req_DV = tbl[i].req;
            bus.i_Req_Byte = tbl[i].bytes;
            tick();
            if (tbl[i].valid) begin
                chk_grant($sformatf("vec%0d", i), tbl[i].idx, tbl[i].byt);
                bus.i_Req_DV = '0;
                tick();
                chk_quiet($sformatf("vec%0d hold", i), 1'b1);
                finish_tx($sformatf("vec%0d", i));
            end else begin
                chk_quiet($sformatf("vec%0d", i), 1'b0);
            end
        end

        bus.i_Req_DV = 4'b1111;
        bus.i_Req_Byte = 32'h1312_1110;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            tick();
            w++;
            while (!bus.o_TX_DV && w < 10) begin
                tick();
                w++;
            end
            chk_grant($sformatf("rr%0d", g), exp_order[g],
                      8'(8'h10 + exp_order[g]));
            chk($sformatf("rr%0d latency", g), 32'(w), 32'd1);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_quiet($sformatf("rr%0d busy", g), 1'b1);
            end
            finish_tx($sformatf("rr%0d", g));
        end
        bus.i_Req_DV = '0;

        bus.i_Req_DV = 4'b1000;
        bus.i_Req_Byte = 32'hD0C0_B0A0;
        tick();
        chk_grant("late", 3, 8'hD0);
        bus.i_Req_DV = '0;
        tick();
        bus.i_Req_DV = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("late wait", 1'b1);
        end
        finish_tx("late");
        tick();
        chk_grant("late grant", 2, 8'hC0);
        bus.i_Req_DV = '0;
        tick();
        finish_tx("late end");

        bus.i_Req_DV = 4'b0001;
        tick();
        chk_grant("drop", 0, 8'hA0);
        bus.i_Req_DV = 4'b0010;
        tick();
        tick();
        bus.i_Req_DV = '0;
        finish_tx("drop");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("drop idle", 1'b0);
        end

        bus.i_Req_DV = 4'b0010;
        tick();
        chk_grant("wd", 1, 8'hB0);
        bus.i_Req_DV = '0;
        for (int c = 0; c < 19; c++) tick();
        chk("wd pre tmo", 32'(bus.o_Timeout), 32'd0);
        chk("wd pre busy", 32'(bus.o_Busy), 32'd1);
        tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("wd tmo", 32'(bus.o_Timeout), 32'd1);
        chk("wd busy", 32'(bus.o_Busy), 32'd0);
        tick();
        chk("wd tmo end", 32'(bus.o_Timeout), 32'd0);
        chk("wd idle", 32'(bus.o_Busy), 32'd0);
`else
        chk("wd tmo", 32'(bus.o_Timeout), 32'd0);
        chk("wd busy", 32'(bus.o_Busy), 32'd1);
        for (int c = 0; c < 10; c++) tick();
        chk("wd still busy", 32'(bus.o_Busy), 32'd1);
        finish_tx("wd");
`endif

        bus.i_Req_DV = 4'b0001;
        bus.i_Req_Byte = 32'h0000_007E;
        tick();
        chk_grant("rst busy", 0, 8'h7E);
        bus.i_Req_DV = 4'b1111;
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk_quiet("rst async", 1'b0);
        chk("rst async byte", 32'(bus.o_TX_Byte), 32'h0);
        chk("rst async idx", 32'(bus.o_Grant_Idx), 32'd3);
        bus.i_Req_DV = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk_quiet("rst no replay", 1'b0);
        bus.i_Req_DV = 4'b1111;
        tick();
        chk_grant("rst regrant", 0, 8'h7E);
        bus.i_Req_DV = '0;
        tick();
        finish_tx("rst regrant");
        last = 0;

        for (int it = 0; it < 200; it++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            b = $urandom();
            bus.i_Req_DV = r;
            bus.i_Req_Byte = b;
            bus.i_TX_Done = ($urandom_range(0, 3) == 0);
            tick();
            bus.i_TX_Done = 1'b0;
            w = model_pick(r, last);
            if (w < 0) begin
                chk_quiet("rnd idle", 1'b0);
            end else begin
                chk_grant("rnd", w, b[8 * w +: 8]);
                last = w;
                len = $urandom_range(1, 6);
                for (int c = 0; c < len; c++) begin
                    bus.i_Req_DV = N'($urandom());
                    bus.i_Req_Byte = $urandom();
                    tick();
                    chk_quiet("rnd busy", 1'b1);
                    chk("rnd hold", 32'(bus.o_TX_Byte), 32'(b[8 * w +: 8]));
                end
                finish_tx("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
